instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch stage upstream of the byte-addressed instruction ROM. It owns the program counter and drives the ROM's combinational byte address. It captures the returned 32-bit little-endian word into an instruction register and hands that register to decode with a valid flag. It handles stall, branch redirect, the all-ones halt word, and out-of-range fetch faults.

## Interface
- WIDTH, 32: instruction width in bits.
- WIDTH_ADD, 6: byte-address width; PC arithmetic is modulo 2^WIDTH_ADD.
- MEM_BYTES, 60: populated ROM bytes; fetch from PC > MEM_BYTES-4 is a fault.
- HALT_WORD, 32'hFFFF_FFFF: end-of-program marker.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  decode back-pressure; freeze PC and instruction register.
- branch_taken  in  1  redirect request from decode, single-cycle pulse.
- branch_target  in  WIDTH_ADD  redirect byte address; bits [1:0] forced to 0.
- imem_address  out  WIDTH_ADD  byte address to ROM, equals PC combinationally.
- imem_data  in  WIDTH  ROM read data, combinational from imem_address.
- instr  out  WIDTH  registered instruction.
- instr_pc  out  WIDTH_ADD  byte address that instr came from.
- instr_valid  out  1  instr is a live instruction for decode.
- halted  out  1  HALT_WORD fetched; fetch stopped.
- fault  out  1  out-of-range fetch; fetch stopped.

## Operation
- States: RUN, HALT, FAULT. Reset enters RUN. HALT and FAULT are absorbing until rst.
- Per-cycle priority in RUN: branch_taken > stall > fault check > halt check > normal fetch.
- branch_taken:
  - PC <= {branch_target[WIDTH_ADD-1:2],2'b00}.
  - instr_valid <= 0, which flushes the wrong-path word.
  - instr and instr_pc hold.
  - A branch asserted together with stall still redirects.
- stall (no branch): PC, instr, instr_pc, instr_valid all hold.
- Fault: PC > MEM_BYTES-4 (e.g. 60) -> FAULT, fault <= 1, instr_valid <= 0, PC holds. The ROM data is ignored.
- Halt: imem_data == HALT_WORD -> HALT, halted <= 1, instr_valid <= 0, PC holds at the halt word address.
- Normal fetch:
  - instr <= imem_data.
  - instr_pc <= PC.
  - instr_valid <= 1.
  - PC <= PC + 4, truncated to WIDTH_ADD bits (60 -> 0 wrap, though the fault check fires first).
- In HALT or FAULT:
  - branch_taken and stall are ignored.
  - instr_valid is 0.
  - instr and instr_pc hold their last values.
  - imem_address keeps presenting the held PC.
- Branch addresses are not checked at request time. An out-of-range target faults on the following fetch cycle.

## Timing
- Reset (asynchronous, immediate): PC=0, imem_address=0, instr=0, instr_pc=0, instr_valid=0, halted=0, fault=0, state=RUN.
- First clock edge after rst deasserts: instr=word@0, instr_valid=1.
- Latency: word at PC appears on instr one edge after PC is presented. Throughput is one instruction per cycle when not stalled.
- Branch penalty: one bubble (instr_valid=0) on the edge of the redirect. The target word appears on the next edge.
- stall takes effect on the same edge it is sampled. The word that was on imem_data is re-fetched after release, so nothing is lost.
- halted and fault assert on the edge that detects the condition. They are never both 1.
- rst asserted mid-run or in HALT/FAULT clears everything asynchronously. No state survives reset.

## Test plan
- Reset then free-run over the fibonacci image:
  - edge 1: instr=32'hE021_0001, instr_pc=0, valid=1.
  - edge 2: instr=32'hE801_0000, instr_pc=4.
  - PC advances by 4 each cycle.
- Stall held for 3 cycles after instr_pc=8:
  - instr stays 32'hE042_0001 and valid stays 1.
  - imem_address stays 12.
  - after release, next instr is 32'hE801_0004 with instr_pc=12.
- branch_taken pulse with branch_target=6'd26:
  - next edge: valid=0, PC=24.
  - following edge: instr=32'hCCA4_0007, instr_pc=24.
  - repeat the pulse with stall=1 simultaneously; the redirect must still occur.
- Run to address 56:
  - halted=1, valid=0, imem_address=56 held.
  - later branch/stall pulses change nothing.
  - rst clears halted and restarts at PC=0.
- branch_target=6'd60:
  - next edge PC=60.
  - following edge fault=1, valid=0, halted=0, PC held at 60.
- Assert rst asynchronously between edges while valid=1 at instr_pc=20: all outputs go to reset values before the next clock edge.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch stage: PC, instruction register, halt and fault handling
module instruction_fetch_unit #(
    parameter int               WIDTH     = 32,
    parameter int               WIDTH_ADD = 6,
    parameter int               MEM_BYTES = 60,
    parameter logic [WIDTH-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [WIDTH_ADD-1:0] branch_target,
    output logic [WIDTH_ADD-1:0] imem_address,
    input  logic [WIDTH-1:0]     imem_data,
    output logic [WIDTH-1:0]     instr,
    output logic [WIDTH_ADD-1:0] instr_pc,
    output logic                 instr_valid,
    output logic                 halted,
    output logic                 fault
);

    // Highest byte address from which a full word can still be read.
    localparam logic [WIDTH_ADD-1:0] LAST_ADDR = WIDTH_ADD'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t               state;
    logic [WIDTH_ADD-1:0] pc;

    // The ROM is combinational, so the PC register is the fetch address.
    assign imem_address = pc;

    // Fetch control: branch beats stall, stall beats fault, fault beats halt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pc          <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (branch_taken) begin
                        // Redirect and squash the word fetched down the wrong path.
                        pc          <= {branch_target[WIDTH_ADD-1:2], 2'b00};
                        instr_valid <= 1'b0;
                    end else if (stall) begin
                        // Everything holds; the current word is fetched again on release.
                        pc          <= pc;
                    end else if (pc > LAST_ADDR) begin
                        // Out-of-range read: the ROM data is meaningless, so do not inspect it.
                        state       <= FAULT;
                        fault       <= 1'b1;
                        instr_valid <= 1'b0;
                    end else if (imem_data == HALT_WORD) begin
                        state       <= HALT;
                        halted      <= 1'b1;
                        instr_valid <= 1'b0;
                    end else begin
                        instr       <= imem_data;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc + WIDTH_ADD'(4);
                    end
                end
                HALT: begin
                    instr_valid <= 1'b0;
                end
                FAULT: begin
                    instr_valid <= 1'b0;
                end
                default: begin
                    state       <= FAULT;
                    fault       <= 1'b1;
                    halted      <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed-vector bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [5:0]  branch_target;
    logic [5:0]  imem_address;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [5:0]  instr_pc;
    logic        instr_valid;
    logic        halted;
    logic        fault;

    int n_vec  = 0;
    int n_miss = 0;

    instruction_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_address  (imem_address),
        .imem_data     (imem_data),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .halted        (halted),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    // Fibonacci program image; bytes beyond the populated ROM read back all-ones.
    function automatic logic [31:0] rom_word(input logic [5:0] a);
        case (a)
            6'd0:    rom_word = 32'hE021_0001;
            6'd4:    rom_word = 32'hE801_0000;
            6'd8:    rom_word = 32'hE042_0001;
            6'd12:   rom_word = 32'hE801_0004;
            6'd16:   rom_word = 32'hE063_0002;
            6'd20:   rom_word = 32'hE801_0008;
            6'd24:   rom_word = 32'hCCA4_0007;
            6'd28:   rom_word = 32'hE084_0003;
            6'd32:   rom_word = 32'hE801_000C;
            6'd36:   rom_word = 32'hE0A5_0004;
            6'd40:   rom_word = 32'hE801_0010;
            6'd44:   rom_word = 32'hE0C6_0005;
            6'd48:   rom_word = 32'hE801_0014;
            6'd52:   rom_word = 32'hE0E7_0006;
            6'd56:   rom_word = 32'hFFFF_FFFF;
            default: rom_word = 32'hFFFF_FFFF;
        endcase
    endfunction

    always_comb imem_data = rom_word(imem_address);

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_vec({tag, ".addr"},   32'(imem_address), 32'd0);
        check_vec({tag, ".instr"},  instr,             32'd0);
        check_vec({tag, ".ipc"},    32'(instr_pc),     32'd0);
        check_vec({tag, ".valid"},  32'(instr_valid),  32'd0);
        check_vec({tag, ".halted"}, 32'(halted),       32'd0);
        check_vec({tag, ".fault"},  32'(fault),        32'd0);
    endtask

    task automatic check_fetch(input string tag, input logic [5:0] a);
        check_vec({tag, ".instr"}, instr,            rom_word(a));
        check_vec({tag, ".ipc"},   32'(instr_pc),    32'(a));
        check_vec({tag, ".valid"}, 32'(instr_valid), 32'd1);
        check_vec({tag, ".addr"},  32'(imem_address), 32'(a + 6'd4));
    endtask

    initial begin
        rst           = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 6'd0;
        #2;
        check_reset_outputs("reset");
        step();
        step();
        @(negedge clk);
        rst = 1'b0;

        // Free run from address 0.
        step();
        check_fetch("run0", 6'd0);
        step();
        check_fetch("run4", 6'd4);
        step();
        check_fetch("run8", 6'd8);

        // Stall for three edges after instr_pc=8.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_vec("stall.instr", instr, 32'hE042_0001);
            check_vec("stall.valid", 32'(instr_valid), 32'd1);
            check_vec("stall.addr",  32'(imem_address), 32'd12);
        end
        stall = 1'b0;
        step();
        check_fetch("release", 6'd12);

        // Branch to 26 (aligned down to 24).
        branch_taken  = 1'b1;
        branch_target = 6'd26;
        step();
        branch_taken = 1'b0;
        check_vec("br.valid", 32'(instr_valid), 32'd0);
        check_vec("br.addr",  32'(imem_address), 32'd24);
        check_vec("br.ipc",   32'(instr_pc),    32'd12);
        check_vec("br.instr", instr,            32'hE801_0004);
        step();
        check_fetch("br.tgt", 6'd24);

        // Branch together with stall still redirects.
        branch_taken = 1'b1;
        stall        = 1'b1;
        step();
        branch_taken = 1'b0;
        stall        = 1'b0;
        check_vec("brst.valid", 32'(instr_valid), 32'd0);
        check_vec("brst.addr",  32'(imem_address), 32'd24);
        step();
        check_fetch("brst.tgt", 6'd24);

        // Run on to the halt word at 56.
        for (int a = 28; a <= 52; a += 4) begin
            step();
            check_fetch("seq", 6'(a));
        end
        step();
        check_vec("halt.halted", 32'(halted),       32'd1);
        check_vec("halt.valid",  32'(instr_valid),  32'd0);
        check_vec("halt.fault",  32'(fault),        32'd0);
        check_vec("halt.addr",   32'(imem_address), 32'd56);
        check_vec("halt.ipc",    32'(instr_pc),     32'd52);

        // Branch/stall ignored while halted.
        branch_taken  = 1'b1;
        stall         = 1'b1;
        branch_target = 6'd8;
        step();
        branch_taken = 1'b0;
        stall        = 1'b0;
        step();
        check_vec("haltign.addr",   32'(imem_address), 32'd56);
        check_vec("haltign.halted", 32'(halted),       32'd1);
        check_vec("haltign.valid",  32'(instr_valid),  32'd0);
        check_vec("haltign.instr",  instr,             32'hE0E7_0006);

        // Reset clears halt and restarts at 0.
        rst = 1'b1;
        #1;
        check_reset_outputs("rsthalt");
        @(negedge clk);
        rst = 1'b0;
        step();
        check_fetch("restart", 6'd0);

        // Branch to 60: next fetch is out of range.
        branch_taken  = 1'b1;
        branch_target = 6'd60;
        step();
        branch_taken = 1'b0;
        check_vec("brf.addr",  32'(imem_address), 32'd60);
        check_vec("brf.valid", 32'(instr_valid),  32'd0);
        step();
        check_vec("fault.fault",  32'(fault),        32'd1);
        check_vec("fault.halted", 32'(halted),       32'd0);
        check_vec("fault.valid",  32'(instr_valid),  32'd0);
        check_vec("fault.addr",   32'(imem_address), 32'd60);
        step();
        check_vec("faulthold.fault", 32'(fault),        32'd1);
        check_vec("faulthold.addr",  32'(imem_address), 32'd60);

        // Asynchronous reset while a live instruction at 20 is presented.
        rst = 1'b1;
        #1;
        check_reset_outputs("rstfault");
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a <= 20; a += 4) begin
            step();
            check_fetch("rerun", 6'(a));
        end
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("asyncrst");
        @(negedge clk);
        rst = 1'b0;
        step();
        check_fetch("postrst", 6'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
